// File: rtl/sobel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Package  : sobel_pkg                                           |
// | Desc     : Shared types, constants and helpers for the 3x3     |
// |            Sobel edge-magnitude pipeline.                      |
// | Revision : 1.0 - initial release                               |
// +----------------------------------------------------------------+
package sobel_pkg;

  typedef logic [7:0]         pix_t;
  typedef logic signed [10:0] grad_t;

  localparam int   c_MAG_W   = 12;
  localparam pix_t c_SAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // |g| widened to the magnitude width; |g| <= 1020 so no overflow.
  function automatic logic [c_MAG_W-1:0] grad_abs(input grad_t g);
    grad_t a;
    a = g[10] ? -g : g;
    return {1'b0, a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_kernel.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : sobel_kernel                                        |
// | Desc     : Combinational 3x3 Sobel magnitude for one 8-bit     |
// |            channel; optional binarization via the macro        |
// |            SOBEL_THRESHOLD_EN.                                 |
// | Revision : 1.0 - initial release                               |
// +----------------------------------------------------------------+
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int THRESHOLD_P = 128
) (
  input  pix_t i_win [3][3],  // [row][col], row 0 is the oldest line
  output pix_t o_result
);

  logic [9:0]         w_xp, w_xn, w_yp, w_yn;
  grad_t              w_gx, w_gy;
  logic [c_MAG_W-1:0] w_mag;
  pix_t               w_sat;
  logic               w_unused_center;

  always_comb begin
    w_xp  = {2'b00, i_win[0][2]} + {1'b0, i_win[1][2], 1'b0} + {2'b00, i_win[2][2]};
    w_xn  = {2'b00, i_win[0][0]} + {1'b0, i_win[1][0], 1'b0} + {2'b00, i_win[2][0]};
    w_yp  = {2'b00, i_win[2][0]} + {1'b0, i_win[2][1], 1'b0} + {2'b00, i_win[2][2]};
    w_yn  = {2'b00, i_win[0][0]} + {1'b0, i_win[0][1], 1'b0} + {2'b00, i_win[0][2]};
    w_gx  = $signed({1'b0, w_xp}) - $signed({1'b0, w_xn});
    w_gy  = $signed({1'b0, w_yp}) - $signed({1'b0, w_yn});
    w_mag = grad_abs(w_gx) + grad_abs(w_gy);
    w_sat = (w_mag > {4'd0, c_SAT_MAX}) ? c_SAT_MAX : w_mag[7:0];
  end

  // The centre tap has zero weight in both gradients.
  assign w_unused_center = ^i_win[1][1];

`ifdef SOBEL_THRESHOLD_EN
  localparam pix_t c_THRESH = pix_t'(THRESHOLD_P);
  assign o_result = (w_sat >= c_THRESH) ? c_SAT_MAX : '0;
`else
  logic w_unused_thr;
  assign w_unused_thr = ^THRESHOLD_P;
  assign o_result     = w_sat;
`endif

endmodule
`default_nettype wire

// File: rtl/sobel_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : sobel_pipeline                                      |
// | Desc     : Streaming 3x3 Sobel edge filter, valid/ready on     |
// |            both sides, one output per input in raster order.   |
// |            Optional threshold build: SOBEL_THRESHOLD_EN.       |
// | Revision : 1.0 - initial release                               |
// +----------------------------------------------------------------+
module sobel_pipeline
  import sobel_pkg::*;
#(
  parameter int WIDTH_P     = 640,
  parameter int HEIGHT_P    = 480,
  parameter int CHANNELS_P  = 1,
  parameter int THRESHOLD_P = 128
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [CHANNELS_P*8-1:0] pixel_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [CHANNELS_P*8-1:0] pixel_o,
  output logic                    last_o
);

  localparam int c_PIX_W = CHANNELS_P * 8;
  localparam int c_COL_W = $clog2(WIDTH_P);
  localparam int c_ROW_W = $clog2(HEIGHT_P);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(WIDTH_P - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(HEIGHT_P - 1);
  localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
  localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

  typedef logic [c_PIX_W-1:0] mpix_t;

  state_t             r_state, w_state_nxt;
  logic [c_COL_W-1:0] r_in_col, r_out_col;
  logic [c_ROW_W-1:0] r_in_row, r_out_row;
  mpix_t              r_lb1 [WIDTH_P];
  mpix_t              r_lb2 [WIDTH_P];
  // Two stored window columns; the third is the live column formed
  // from the line buffers and pixel_i, so the result is ready on accept.
  mpix_t              r_win [3][2];
  mpix_t              w_col_new [3];
  mpix_t              w_kernel_out;
  logic               w_in_fire, w_out_free, w_load, w_in_last;
  logic               w_out_border, w_out_last;

  assign w_out_free   = !valid_o || ready_i;
  assign w_in_fire    = valid_i && ready_o;
  assign w_in_last    = (r_in_col == c_COL_LAST) && (r_in_row == c_ROW_LAST);
  assign w_out_border = (r_out_col == '0) || (r_out_col == c_COL_LAST) ||
                        (r_out_row == '0) || (r_out_row == c_ROW_LAST);
  assign w_out_last   = (r_out_col == c_COL_LAST) && (r_out_row == c_ROW_LAST);

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      FILL: begin
        ready_o = 1'b1;
        if (valid_i && (r_in_col == '0) && (r_in_row == c_ROW_ONE))
          w_state_nxt = STREAM;
      end
      STREAM: begin
        ready_o = w_out_free;
        w_load  = valid_i && w_out_free;
        if (w_load && w_in_last)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Stop loading once the final pixel sits in the output register.
        w_load = w_out_free && !(valid_o && last_o);
        if (valid_o && ready_i && last_o)
          w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= FILL;
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      pixel_o   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_fire) begin
        if (r_in_col == c_COL_LAST) begin
          r_in_col <= '0;
          r_in_row <= (r_in_row == c_ROW_LAST) ? '0 : r_in_row + c_ROW_ONE;
        end else begin
          r_in_col <= r_in_col + c_COL_ONE;
        end
      end
      if (w_load) begin
        if (r_out_col == c_COL_LAST) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == c_ROW_LAST) ? '0 : r_out_row + c_ROW_ONE;
        end else begin
          r_out_col <= r_out_col + c_COL_ONE;
        end
        valid_o <= 1'b1;
        pixel_o <= w_out_border ? '0 : w_kernel_out;
        last_o  <= w_out_last;
      end else if (ready_i) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_col_new[0] = r_lb2[r_in_col];
    w_col_new[1] = r_lb1[r_in_col];
    w_col_new[2] = pixel_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_in_fire) begin
      r_lb2[r_in_col] <= r_lb1[r_in_col];
      r_lb1[r_in_col] <= pixel_i;
      for (int y = 0; y < 3; y++) begin
        r_win[y][0] <= r_win[y][1];
        r_win[y][1] <= w_col_new[y];
      end
    end
  end

  for (genvar ch = 0; ch < CHANNELS_P; ch++) begin : g_chan
    pix_t w_kwin [3][3];
    always_comb begin
      for (int y = 0; y < 3; y++) begin
        w_kwin[y][0] = r_win[y][0][ch*8 +: 8];
        w_kwin[y][1] = r_win[y][1][ch*8 +: 8];
        w_kwin[y][2] = w_col_new[y][ch*8 +: 8];
      end
    end
    sobel_kernel #(
      .THRESHOLD_P (THRESHOLD_P)
    ) u_kernel (
      .i_win    (w_kwin),
      .o_result (w_kernel_out[ch*8 +: 8])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : tb_sobel_pipeline                                   |
// | Desc     : Directed self-checking bench for sobel_pipeline,    |
// |            8x6 frames, three channels.                         |
// | Revision : 1.0 - initial release                               |
// +----------------------------------------------------------------+
module tb_sobel_pipeline;

  localparam int W = 8;
  localparam int H = 6;
  localparam int C = 3;
  localparam int N = W * H;

  logic           clk;
  logic           reset_i;
  logic           valid_i;
  logic           ready_o;
  logic [C*8-1:0] pixel_i;
  logic           valid_o;
  logic           ready_i;
  logic [C*8-1:0] pixel_o;
  logic           last_o;

  int n_cmp;
  int n_fail;

  logic [C*8-1:0] frame_in [N];
  logic [C*8-1:0] exp_pix  [N];
  logic [C*8-1:0] got_pix  [N];
  logic           got_last [N];

  sobel_pipeline #(
    .WIDTH_P     (W),
    .HEIGHT_P    (H),
    .CHANNELS_P  (C),
    .THRESHOLD_P (128)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .pixel_i (pixel_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .pixel_o (pixel_o),
    .last_o  (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit interior(int c, int r);
    return (c > 0) && (c < W-1) && (r > 0) && (r < H-1);
  endfunction

  // Hand-derived patterns: a vertical step saturates columns 3/4,
  // a 0x0A horizontal step yields Gy=40 (0x28) on rows 2/3.
  function automatic logic [7:0] vert_in(int c);
    return (c >= 4) ? 8'hFF : 8'h00;
  endfunction
  function automatic logic [7:0] vert_exp(int c, int r);
    return (interior(c, r) && (c == 3 || c == 4)) ? 8'hFF : 8'h00;
  endfunction
  function automatic logic [7:0] horiz_in(int r);
    return (r >= 3) ? 8'h0A : 8'h00;
  endfunction
  function automatic logic [7:0] horiz_exp(int c, int r);
    return (interior(c, r) && (r == 2 || r == 3)) ? 8'h28 : 8'h00;
  endfunction

  // Direct 2-D reference over the whole stored frame.
  function automatic logic [7:0] ref_sobel(int c, int r, int ch);
    int p [3][3];
    int gx, gy, m;
    logic [C*8-1:0] px;
    if (!interior(c, r)) return 8'h00;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        px = frame_in[(r+dy-1)*W + (c+dx-1)];
        p[dy][dx] = int'(px[ch*8 +: 8]);
      end
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 8'hFF : m[7:0];
  endfunction

  task automatic fill_vertical();
    for (int k = 0; k < N; k++) begin
      frame_in[k] = {C{vert_in(k % W)}};
      exp_pix[k]  = {C{vert_exp(k % W, k / W)}};
    end
  endtask

  // Streams frame_in through the DUT and checks every output and handshake rule.
  task automatic run_frame(input bit gaps, input bit bp, input string tag);
    int in_idx, out_idx, cyc;
    bit hold;
    logic [C*8-1:0] hold_pix;
    logic hold_last;
    in_idx = 0; out_idx = 0; cyc = 0; hold = 1'b0; hold_pix = '0; hold_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      got_pix[k]  = 'x;
      got_last[k] = 1'bx;
    end
    while (out_idx < N && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      ready_i = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (in_idx < N) begin
        valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        pixel_i = frame_in[in_idx];
      end else begin
        valid_i = 1'b0;
        pixel_i = '0;
      end
      #1;
      if (hold) begin
        n_cmp++;
        if (valid_o !== 1'b1 || pixel_o !== hold_pix || last_o !== hold_last) begin
          n_fail++;
          $display("FAIL %s hold_stable: valid=%b pixel=%h last=%b, required valid=1 pixel=%h last=%b",
                   tag, valid_o, pixel_o, last_o, hold_pix, hold_last);
        end
      end
      if (in_idx == N) begin
        n_cmp++;
        if (ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s drain_ready: ready_o=%b, required 0", tag, ready_o);
        end
      end
      if (in_idx <= W) begin
        n_cmp++;
        if (valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fill_valid: valid_o=%b after %0d inputs, required 0", tag, valid_o, in_idx);
        end
      end
      if (valid_o === 1'b0) begin
        n_cmp++;
        if (last_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s last_idle: last_o=%b with valid_o=0, required 0", tag, last_o);
        end
      end
      hold      = valid_o && !ready_i;
      hold_pix  = pixel_o;
      hold_last = last_o;
      if (valid_o && ready_i) begin
        got_pix[out_idx]  = pixel_o;
        got_last[out_idx] = last_o;
        out_idx++;
      end
      if (valid_i && ready_o) in_idx++;
    end
    n_cmp++;
    if (out_idx != N) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d outputs, required %0d", tag, out_idx, N);
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got_pix[k] !== exp_pix[k] || got_last[k] !== (k == N-1)) begin
        n_fail++;
        $display("FAIL %s pixel[%0d] (c=%0d r=%0d): got %h last=%b, required %h last=%b",
                 tag, k, k % W, k / W, got_pix[k], got_last[k], exp_pix[k], (k == N-1));
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; pixel_i = '0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || pixel_o !== '0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b pixel=%h ready=%b, required 0 0 000000 1",
               valid_o, last_o, pixel_o, ready_o);
    end
  endtask

  task automatic test_uniform();
    for (int k = 0; k < N; k++) begin
      frame_in[k] = {C{8'h80}};
      exp_pix[k]  = '0;
    end
    run_frame(1'b0, 1'b0, "uniform");
  endtask

  task automatic test_vertical_edge();
    fill_vertical();
    run_frame(1'b0, 1'b0, "vertical_edge");
  endtask

  task automatic test_horizontal_edge();
    for (int k = 0; k < N; k++) begin
      frame_in[k] = {C{horiz_in(k / W)}};
      exp_pix[k]  = {C{horiz_exp(k % W, k / W)}};
    end
    run_frame(1'b0, 1'b0, "horizontal_edge");
  endtask

  task automatic test_random_backpressure();
    for (int k = 0; k < N; k++) frame_in[k] = C*8'($urandom);
    for (int k = 0; k < N; k++)
      for (int ch = 0; ch < C; ch++)
        exp_pix[k][ch*8 +: 8] = ref_sobel(k % W, k / W, ch);
    run_frame(1'b1, 1'b1, "random_bp");
  endtask

  task automatic test_reset_midframe();
    int acc, cyc;
    acc = 0; cyc = 0;
    for (int k = 0; k < N; k++) frame_in[k] = C*8'($urandom);
    while (acc < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ready_i = 1'b1;
      valid_i = 1'b1;
      pixel_i = frame_in[acc];
      #1;
      if (ready_o) acc++;
    end
    n_cmp++;
    if (acc != 20) begin
      n_fail++;
      $display("FAIL midframe_accept: accepted %0d pixels, required 20", acc);
    end
    @(negedge clk);
    valid_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || pixel_o !== '0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_reset_state: valid=%b last=%b pixel=%h ready=%b, required 0 0 000000 1",
               valid_o, last_o, pixel_o, ready_o);
    end
    fill_vertical();
    run_frame(1'b0, 1'b0, "reset_recover");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < N; k++) begin
      frame_in[k] = {horiz_in(k / W), vert_in(k % W), 8'h80};
      exp_pix[k]  = {horiz_exp(k % W, k / W), vert_exp(k % W, k / W), 8'h00};
    end
    run_frame(1'b0, 1'b0, "b2b_frame1");
    run_frame(1'b0, 1'b1, "b2b_frame2");
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    pixel_i = '0;
    test_reset();
    test_uniform();
    test_vertical_edge();
    test_horizontal_edge();
    test_random_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_pipeline.md
Name: sobel_pipeline

Overview:
- Streaming 3x3 Sobel edge-magnitude filter for raster-scan frames of WIDTH_P x HEIGHT_P pixels, CHANNELS_P 8-bit channels per pixel.
- Sits between a pixel source and a pixel sink.
- Both sides use valid/ready handshakes.
- Emits exactly one output pixel per input pixel, in raster order, and flags the final pixel of each frame.

Parameters:
- WIDTH_P, 640, pixels per row (>=3).
- HEIGHT_P, 480, rows per frame (>=3).
- CHANNELS_P, 1, 8-bit channels per pixel; each channel is filtered independently.
- THRESHOLD_P, 128, binarization threshold; used only with SOBEL_THRESHOLD_EN.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  pixel_i is valid.
- ready_o  out  1  block accepts pixel_i this cycle.
- pixel_i  in  CHANNELS_P*8  input pixel; channel n occupies bits [8n+7:8n].
- valid_o  out  1  pixel_o is valid.
- ready_i  in  1  sink accepts pixel_o.
- pixel_o  out  CHANNELS_P*8  filtered pixel, same packing as pixel_i.
- last_o  out  1  pixel_o is the final pixel (index W*H-1) of the frame; qualified by valid_o.

Behaviour:
- Handshake rules:
  - Input transfer occurs when valid_i & ready_o at a rising edge.
  - Output transfer occurs when valid_o & ready_i at a rising edge.
  - valid_o, pixel_o and last_o are registered and must hold stable until transferred.
- Reset: valid_o=0, last_o=0, pixel_o=0, ready_o=1 in the cycle after reset. All counters and state return to FILL. Line-buffer contents need not be cleared. Reset mid-frame abandons the frame; the next accepted pixel is treated as (0,0).
- Storage:
  - Two line buffers of WIDTH_P pixels.
  - A 3x3 window register array.
  - Input column/row counters.
  - Output pixel counter.
- States FILL, STREAM, DRAIN:
  - FILL (first W+1 accepted pixels of a frame): ready_o=1; no output produced. Move to STREAM when the (W+1)th pixel is accepted.
  - STREAM: every accepted input pixel with linear index k causes output pixel k-(W+1) to be loaded into the output register on the same edge. ready_o = !valid_o | ready_i (no loss, no duplication under backpressure). Move to DRAIN when pixel W*H-1 is accepted.
  - DRAIN: ready_o=0. Emit the remaining W+1 output pixels, one per cycle while the sink is ready. Return to FILL when the pixel with last_o is transferred. A new frame may then start immediately.
- Output value for pixel (c,r):
  - Border pixels (c=0, c=W-1, r=0 or r=H-1) are 0 on all channels.
  - Interior pixels, per channel, over window p[dy][dx] (dy, dx in -1..1):
    - Gx = (p[-1][1] + 2p[0][1] + p[1][1]) - (p[-1][-1] + 2p[0][-1] + p[1][-1]).
    - Gy = (p[1][-1] + 2p[1][0] + p[1][1]) - (p[-1][-1] + 2p[-1][0] + p[-1][1]).
    - Gx and Gy are signed 11-bit.
    - out = min(|Gx| + |Gy|, 255), computed at 12 bits then saturated to 8 bits.
  - All DRAIN outputs are border pixels, so all are 0.
- Latency: output pixel k is valid in the cycle after input pixel k+W+1 is accepted (STREAM), or after the previous output is transferred (DRAIN).
- last_o: high only alongside output index W*H-1; 0 whenever valid_o=0.
- Simultaneous input accept and output transfer in the same cycle is legal and sustains one pixel per cycle.

Optional Feature:
- Macro SOBEL_THRESHOLD_EN.
- When defined, each interior channel output is 255 if the saturated magnitude >= THRESHOLD_P, else 0. Borders remain 0.
- When undefined, the output is the saturated magnitude. THRESHOLD_P is unused and timing/latency are identical in both builds.

Decomposition:
- Package sobel_pkg:
  - pixel channel typedef (8-bit).
  - signed gradient typedef (11-bit).
  - magnitude width constant (12).
  - saturation max constant 255.
  - state enum {FILL, STREAM, DRAIN}.
- One sub-module sobel_kernel: purely combinational. Takes a 3x3 window for one channel and returns the 8-bit result (including the optional threshold). Instantiated CHANNELS_P times.

Test Plan:
1. W=8, H=6, C=1, uniform 0x80 frame, ready_i=1 -> 48 outputs all 0x00; last_o only on the 48th; ready_o=0 during the 9 drain outputs.
2. W=8, H=6, columns 0-3 = 0x00, columns 4-7 = 0xFF -> interior columns 3 and 4 = 0xFF (Gx=1020, saturated); other interior and all border pixels = 0x00.
3. W=8, H=6, rows 0-2 = 0x00, rows 3-5 = 0x0A -> interior rows 2 and 3 = 0x28 (Gy=40); other pixels = 0x00.
4. Random 8x6 frame with ready_i toggled pseudo-randomly and valid_i gapped -> output stream bit-identical to a software model; no pixel lost or duplicated; pixel_o stable while valid_o & !ready_i.
5. Reset asserted after 20 input pixels, then a full frame from test 2 -> valid_o=0 the cycle after reset; the result matches test 2 exactly.
6. Two back-to-back frames (C=3, channels carrying the patterns of tests 1, 2 and 3) -> per-channel results match; last_o once per frame; frame 2 accepted only after frame 1's last_o transfer.
